// File: rtl/md_pkg.sv
// Shared molecular-dynamics ring types: packet format and cell/ID sizing.
package md_pkg;

    localparam int NUM_CELLS     = 16;
    localparam int NODE_ID_WIDTH = $clog2(NUM_CELLS);
    localparam int PAYLOAD_WIDTH = 16;

    typedef struct packed {
        logic                     valid;
        logic [NODE_ID_WIDTH-1:0] dest_id;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } packet_t;

endpackage

// File: rtl/ring_inject_fifo.sv
// Local injection FIFO: circular buffer with power-of-two depth, head always visible.
module ring_inject_fifo
    import md_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = packet_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    T               mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW:0]    count_r;
    logic           full_s;
    logic           do_push_s;
    logic           do_pop_s;

    assign full_s    = (count_r == (PW+1)'(DEPTH));
    assign do_push_s = push && !full_s;
    assign do_pop_s  = pop && (count_r != '0);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;

endmodule

// File: rtl/ring_node.sv
// Bufferless ring stop: ring traffic has priority, local packets inject into free slots.
module ring_node
    import md_pkg::*;
#(
    parameter int NODE_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  packet_t                       local_pkt_in,
    output logic                          local_in_ready,
    input  packet_t                       ring_in,
    output packet_t                       ring_out,
    output packet_t                       eject_pkt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   stall_cycles
);

    localparam logic [NODE_ID_WIDTH-1:0] SELF_ID = NODE_ID_WIDTH'(NODE_ID);

    packet_t                        head_s;
    logic [$clog2(FIFO_DEPTH):0]    count_s;
    logic                           full_s;
    logic                           push_s;
    logic                           pop_s;
    logic                           have_head_s;
    logic                           head_self_s;
    packet_t                        ring_nxt_s;
    packet_t                        eject_nxt_s;
    packet_t                        ring_out_r;
    packet_t                        eject_r;
    logic [15:0]                    stall_r;

    assign local_in_ready = !full_s;
    assign push_s         = local_pkt_in.valid && !full_s;
    assign have_head_s    = (count_s != '0);
    assign head_self_s    = (head_s.dest_id == SELF_ID);

    ring_inject_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (packet_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (local_pkt_in),
        .pop   (pop_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s)
    );

    // Slot arbitration: ring first, head fills the free ring slot or the eject port.
    always_comb begin
        pop_s             = 1'b0;
        ring_nxt_s        = ring_in;
        ring_nxt_s.valid  = 1'b0;
        eject_nxt_s       = ring_in;
        eject_nxt_s.valid = 1'b0;
        if (ring_in.valid) begin
            if (ring_in.dest_id == SELF_ID) begin
                eject_nxt_s = ring_in;
                // A self-destined head must wait: the eject port is taken.
                if (have_head_s && !head_self_s) begin
                    ring_nxt_s       = head_s;
                    ring_nxt_s.valid = 1'b1;
                    pop_s            = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end else begin
                ring_nxt_s = ring_in;
            end
        end else if (have_head_s) begin
            pop_s = 1'b1;
            if (head_self_s) begin
                eject_nxt_s       = head_s;
                eject_nxt_s.valid = 1'b1;
            end else begin
                ring_nxt_s        = head_s;
                ring_nxt_s.valid  = 1'b1;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Output registers toward the downstream node and the force accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_out_r <= '0;
            eject_r    <= '0;
        end else begin
            ring_out_r <= ring_nxt_s;
            eject_r    <= eject_nxt_s;
        end
    end

    // Saturating stall counter: waiting packets that could not leave this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_r <= 16'h0000;
        end else if (have_head_s && !pop_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign ring_out     = ring_out_r;
    assign eject_pkt    = eject_r;
    assign fifo_count   = count_s;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_ring_node.sv
// Directed bench for ring_node (NODE_ID=5, depth 4): vector table plus corner sequences.
module tb_ring_node;
    import md_pkg::*;

    localparam int NID = 5;
    localparam int DEP = 4;

    logic        clk;
    logic        rst;
    packet_t     local_pkt_in;
    logic        local_in_ready;
    packet_t     ring_in;
    packet_t     ring_out;
    packet_t     eject_pkt;
    logic [2:0]  fifo_count;
    logic [15:0] stall_cycles;

    int n_tests;
    int n_fail;

    ring_node #(.NODE_ID(NID), .FIFO_DEPTH(DEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .local_pkt_in   (local_pkt_in),
        .local_in_ready (local_in_ready),
        .ring_in        (ring_in),
        .ring_out       (ring_out),
        .eject_pkt      (eject_pkt),
        .fifo_count     (fifo_count),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [3:0]  rd;
        logic [15:0] rp;
        logic        lv;
        logic [3:0]  ld;
        logic [15:0] lp;
        logic        ro_v;
        logic [3:0]  ro_d;
        logic [15:0] ro_p;
        logic        ej_v;
        logic [3:0]  ej_d;
        logic [15:0] ej_p;
        logic [2:0]  cnt;
        logic        rdy;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [3:0] rd, input logic [15:0] rp,
                         input logic lv, input logic [3:0] ld, input logic [15:0] lp);
        ring_in      = '{valid: rv, dest_id: rd, payload: rp};
        local_pkt_in = '{valid: lv, dest_id: ld, payload: lp};
    endtask

    task automatic reset_dut();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

        //            rv  rd     rp        lv  ld     lp        ro_v ro_d  ro_p      ej_v ej_d  ej_p      cnt   rdy   stall
        vecs[0]  = '{1'b1,4'd7,16'h0070, 1'b0,4'd0,16'h0000, 1'b1,4'd7,16'h0070, 1'b0,4'd0,16'h0000, 3'd0,1'b1,16'd0};
        vecs[1]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd9,16'h0091, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 3'd1,1'b1,16'd0};
        vecs[2]  = '{1'b1,4'd5,16'h0051, 1'b0,4'd0,16'h0000, 1'b1,4'd9,16'h0091, 1'b1,4'd5,16'h0051, 3'd0,1'b1,16'd0};
        vecs[3]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd5,16'h0052, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 3'd1,1'b1,16'd0};
        vecs[4]  = '{1'b1,4'd5,16'h0053, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd5,16'h0053, 3'd1,1'b1,16'd1};
        vecs[5]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd5,16'h0052, 3'd0,1'b1,16'd1};
        vecs[6]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd3,16'h0031, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 3'd1,1'b1,16'd1};
        vecs[7]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd4,16'h0041, 1'b1,4'd3,16'h0031, 1'b0,4'd0,16'h0000, 3'd1,1'b1,16'd1};
        vecs[8]  = '{1'b1,4'd2,16'h0021, 1'b1,4'd5,16'h0055, 1'b1,4'd2,16'h0021, 1'b0,4'd0,16'h0000, 3'd2,1'b1,16'd2};
        vecs[9]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd4,16'h0041, 1'b0,4'd0,16'h0000, 3'd1,1'b1,16'd2};
        vecs[10] = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd5,16'h0055, 3'd0,1'b1,16'd2};
        vecs[11] = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 3'd0,1'b1,16'd2};

        reset_dut();
        chk("rst_ro_valid", 32'(ring_out.valid), 32'd0);
        chk("rst_ej_valid", 32'(eject_pkt.valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(local_in_ready), 32'd1);
        chk("rst_stall", 32'(stall_cycles), 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rv, vecs[i].rd, vecs[i].rp, vecs[i].lv, vecs[i].ld, vecs[i].lp);
            tick();
            chk($sformatf("v%0d_ro_valid", i), 32'(ring_out.valid), 32'(vecs[i].ro_v));
            chk($sformatf("v%0d_ej_valid", i), 32'(eject_pkt.valid), 32'(vecs[i].ej_v));
            if (vecs[i].ro_v) begin
                chk($sformatf("v%0d_ro_dest", i), 32'(ring_out.dest_id), 32'(vecs[i].ro_d));
                chk($sformatf("v%0d_ro_pay", i), 32'(ring_out.payload), 32'(vecs[i].ro_p));
            end
            if (vecs[i].ej_v) begin
                chk($sformatf("v%0d_ej_dest", i), 32'(eject_pkt.dest_id), 32'(vecs[i].ej_d));
                chk($sformatf("v%0d_ej_pay", i), 32'(eject_pkt.payload), 32'(vecs[i].ej_p));
            end
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_ready", i), 32'(local_in_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_stall", i), 32'(stall_cycles), 32'(vecs[i].stall));
        end

        // Blocked ring: one idle-ring push, then 10 busy cycles with more pushes.
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            if (i >= 1) drive(1'b1, 4'd2, 16'(16'h0100 + i), 1'b0, 4'd0, 16'h0);
            else        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0);
            if (i < 6) begin
                chk($sformatf("blk%0d_ready", i), 32'(local_in_ready), (i < 4) ? 32'd1 : 32'd0);
                local_pkt_in = '{valid: 1'b1, dest_id: 4'd8, payload: 16'(16'h00A0 + i)};
            end
            tick();
            chk($sformatf("blk%0d_ro_valid", i), 32'(ring_out.valid), (i >= 1) ? 32'd1 : 32'd0);
            if (i >= 1) chk($sformatf("blk%0d_ro_pay", i), 32'(ring_out.payload), 32'(16'h0100 + i));
            chk($sformatf("blk%0d_ej_valid", i), 32'(eject_pkt.valid), 32'd0);
        end
        chk("blk_count", 32'(fifo_count), 32'd4);
        chk("blk_stall", 32'(stall_cycles), 32'd10);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain%0d_ro_valid", k), 32'(ring_out.valid), 32'd1);
            chk($sformatf("drain%0d_ro_pay", k), 32'(ring_out.payload), 32'(16'h00A0 + k));
            chk($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(3 - k));
        end
        tick();
        chk("drain_end_ro_valid", 32'(ring_out.valid), 32'd0);
        chk("drain_end_stall", 32'(stall_cycles), 32'd10);

        // Mid-cycle reset with a populated FIFO and both outputs valid.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd2, 16'h0200, 1'b1, 4'd8, 16'(16'h00B0 + i));
            tick();
        end
        drive(1'b1, 4'd5, 16'h005A, 1'b1, 4'd8, 16'h00B3);
        tick();
        chk("pre_rst_ro_valid", 32'(ring_out.valid), 32'd1);
        chk("pre_rst_ro_pay", 32'(ring_out.payload), 32'h00B0);
        chk("pre_rst_ej_valid", 32'(eject_pkt.valid), 32'd1);
        chk("pre_rst_ej_pay", 32'(eject_pkt.payload), 32'h005A);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ro_valid", 32'(ring_out.valid), 32'd0);
        chk("async_rst_ej_valid", 32'(eject_pkt.valid), 32'd0);
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        chk("async_rst_ready", 32'(local_in_ready), 32'd1);
        chk("async_rst_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d_ro_valid", k), 32'(ring_out.valid), 32'd0);
            chk($sformatf("post_rst%0d_ej_valid", k), 32'(eject_pkt.valid), 32'd0);
            chk($sformatf("post_rst%0d_count", k), 32'(fifo_count), 32'd0);
        end

        // Stall saturation: one packet held back by an always-busy ring.
        reset_dut();
        drive(1'b1, 4'd2, 16'h0300, 1'b1, 4'd8, 16'h00C0);
        tick();
        local_pkt_in = '{valid: 1'b0, dest_id: 4'd0, payload: 16'h0};
        for (int k = 0; k < 65534; k++) begin
            tick();
        end
        chk("sat_stall_fffe", 32'(stall_cycles), 32'h0000FFFE);
        tick();
        chk("sat_stall_ffff", 32'(stall_cycles), 32'h0000FFFF);
        repeat (5) tick();
        chk("sat_stall_hold", 32'(stall_cycles), 32'h0000FFFF);
        chk("sat_count", 32'(fifo_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_node.md
RING_NODE -- requirements
Module: ring_node

Interface
REQ-001 Parameter NODE_ID, default 0, ring position of this node; equals the home cell ID of the attached cell.
REQ-002 Parameter FIFO_DEPTH, default 4, local injection FIFO depth; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 local_pkt_in  input  packet_t  packet from the cell's destination-ID mapper; qualified by its valid field.
REQ-006 local_in_ready  output  1  high when the FIFO can accept local_pkt_in this cycle.
REQ-007 ring_in  input  packet_t  packet from the upstream ring node.
REQ-008 ring_out  output  packet_t  registered packet to the downstream ring node.
REQ-009 eject_pkt  output  packet_t  registered packet delivered to the local force accumulator; always accepted.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 stall_cycles  output  16  saturating count of cycles with a non-empty FIFO and no injection.

Function
REQ-012 Push: when local_pkt_in.valid && local_in_ready, the packet is written to the FIFO tail at the edge.
REQ-013 local_in_ready = (fifo_count != FIFO_DEPTH); it is a function of registered state only. When full, ready is low even if a pop occurs the same cycle.
REQ-014 Ring traffic is bufferless: ring_in is never back-pressured and always has priority over local injection.
REQ-015 Each cycle, exactly one case applies, evaluated in order:
- (a) ring_in.valid && ring_in.dest_id==NODE_ID: eject_pkt<=ring_in. The ring slot is free, so the FIFO head (if any, with dest_id!=NODE_ID) goes to ring_out and is popped.
- (b) ring_in.valid && dest_id!=NODE_ID: ring_out<=ring_in; no pop.
- (c) ring_in invalid and FIFO head dest_id!=NODE_ID: head goes to ring_out and is popped.
- (d) ring_in invalid and FIFO head dest_id==NODE_ID: head goes to eject_pkt and is popped; ring_out is invalid.
- In any case not driving an output, that output's valid is 0 next cycle.
REQ-016 A self-destined FIFO head is never placed on the ring. Under case (a) it waits, because the eject port carries one packet per cycle.
REQ-017 Latency: ring_in to ring_out or eject_pkt is exactly 1 cycle. A local packet accepted at edge t reaches ring_out or eject_pkt no earlier than edge t+1. There is no FIFO bypass.
REQ-018 Simultaneous push and pop when not full: fifo_count is unchanged and order is preserved (strict FIFO).
REQ-019 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-020 stall_cycles increments when fifo_count!=0 and no pop occurs; it saturates at 16'hFFFF.
REQ-021 When an output is invalid, its non-valid packet fields are don't-care. Outputs may hold stale data.

Reset
REQ-022 While rst is high, the following are cleared asynchronously: ring_out.valid=0, eject_pkt.valid=0, FIFO pointers=0, fifo_count=0, stall_cycles=0, local_in_ready=1 (once count is 0).
REQ-023 Reset mid-operation discards FIFO contents and in-flight output registers. No packet is emitted after reset deasserts unless it is newly received.

Structure
REQ-024 packet_t (fields valid, dest_id, payload), NODE_ID_WIDTH and NUM_CELLS reside in md_pkg. The block adds no new package types.
REQ-025 The injection FIFO is one sub-module, ring_inject_fifo, parameterised by depth and element type packet_t. It provides push, pop, head, count and full.
REQ-026 The top of ring_node contains only the priority/select logic, output registers and stall counter.

Verification
REQ-027 NODE_ID=5, FIFO empty, ring_in valid dest 7 -> ring_out valid dest 7 next cycle; eject invalid; fifo_count 0.
REQ-028 FIFO head dest 9, ring_in valid dest 5 -> next cycle eject_pkt dest 5 and ring_out dest 9; fifo_count decrements by 1.
REQ-029 ring_in valid dest 2 for 10 consecutive cycles, 6 local pushes attempted -> 4 accepted, local_in_ready low after the 4th, no injection, stall_cycles=10. Then ring_in goes idle -> 4 packets exit in push order on consecutive cycles.
REQ-030 FIFO head dest 5 while ring_in valid dest 5 -> ring packet ejected first; head ejected the following cycle if ring_in is idle; ring_out stays invalid throughout.
REQ-031 fifo_count=3 with ring_out and eject valid, rst pulsed mid-cycle -> all valids 0 and fifo_count 0 immediately; after release, no output until new input.
REQ-032 stall_cycles preloaded near 16'hFFFF (forced) with a blocked FIFO -> holds 16'hFFFF without wrapping.
